calc_frame_rx: RTL

- Sits between the UART byte receiver and the calculator datapath.
- Assembles a 9-byte command frame from the byte stream: operand A (4 bytes), operand B (4 bytes), op (1 byte).
- Presents A, B and op to the ALU/TX path with a valid/ready handshake.
- Adds inter-byte timeout resync and frame-format checking, so a lost byte cannot permanently misalign operands.

---
 rtl/calc_frame_rx.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/calc_frame_rx.sv
// Frame assembler between the UART receiver and the calculator datapath: A(4B) B(4B) op(1B), big-endian.
// Optional macro CALC_FRAME_CHECKSUM_EN adds a trailing XOR checksum byte (10-byte frame).
module calc_frame_rx #(
    parameter int CYCLES_TIMEOUT = 10400,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [31:0] cmd_a,
    output logic [31:0] cmd_b,
    output logic [3:0]  cmd_op,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        err_timeout,
    output logic        err_format,
    output logic        overrun,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RECV = 2'd1, ST_HOLD = 2'd2} state_t;

`ifdef CALC_FRAME_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd9;
`else
    localparam logic [3:0] LAST_IDX = 4'd8;
`endif
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(CYCLES_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [3:0]        count_q, count_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       a_sh_q, a_sh_d, b_sh_q, b_sh_d;
    logic [31:0]       cmd_a_q, cmd_a_d, cmd_b_q, cmd_b_d;
    logic [3:0]        cmd_op_q, cmd_op_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_format_q, err_format_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        op_byte_s;
    logic              frame_ok_s;
`ifdef CALC_FRAME_CHECKSUM_EN
    logic [7:0]        op_sh_q, op_sh_d, xor_q, xor_d;
`endif

    // Next-state, shadow assembly and registered-output computation
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        tmo_d         = tmo_q;
        a_sh_d        = a_sh_q;
        b_sh_d        = b_sh_q;
        cmd_a_d       = cmd_a_q;
        cmd_b_d       = cmd_b_q;
        cmd_op_d      = cmd_op_q;
        cmd_valid_d   = cmd_valid_q;
        err_timeout_d = 1'b0;
        err_format_d  = 1'b0;
        overrun_d     = 1'b0;
`ifdef CALC_FRAME_CHECKSUM_EN
        op_sh_d       = op_sh_q;
        xor_d         = xor_q;
        op_byte_s     = op_sh_q;
        frame_ok_s    = (op_sh_q[7:4] == 4'd0) && (byte_in == xor_q);
`else
        op_byte_s     = byte_in;
        frame_ok_s    = (byte_in[7:4] == 4'd0);
`endif
        case (state_q)
            ST_IDLE: begin
                if (byte_valid) begin
                    a_sh_d  = {a_sh_q[23:0], byte_in};
                    count_d = 4'd1;
                    tmo_d   = '0;
                    state_d = ST_RECV;
`ifdef CALC_FRAME_CHECKSUM_EN
                    xor_d   = byte_in;
`endif
                end else begin
                    tmo_d = '0;
                end
            end
            ST_RECV: begin
                if (byte_valid) begin
                    // Shifting in MSB-first leaves each operand big-endian after its fourth byte
                    case (count_q)
                        4'd0, 4'd1, 4'd2, 4'd3: a_sh_d = {a_sh_q[23:0], byte_in};
                        4'd4, 4'd5, 4'd6, 4'd7: b_sh_d = {b_sh_q[23:0], byte_in};
                        default: begin
`ifdef CALC_FRAME_CHECKSUM_EN
                            if (count_q == 4'd8) begin
                                op_sh_d = byte_in;
                            end else begin
                                op_sh_d = op_sh_q;
                            end
`else
                            a_sh_d = a_sh_q;
`endif
                        end
                    endcase
`ifdef CALC_FRAME_CHECKSUM_EN
                    xor_d = xor_q ^ byte_in;
`endif
                    tmo_d   = '0;
                    count_d = count_q + 4'd1;
                    if (count_q == LAST_IDX) begin
                        count_d = 4'd0;
                        if (frame_ok_s) begin
                            cmd_a_d     = a_sh_q;
                            cmd_b_d     = b_sh_q;
                            cmd_op_d    = op_byte_s[3:0];
                            cmd_valid_d = 1'b1;
                            state_d     = ST_HOLD;
                        end else begin
                            err_format_d = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_RECV;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_timeout_d = 1'b1;
                    count_d       = 4'd0;
                    tmo_d         = '0;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                overrun_d = byte_valid;
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    cmd_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                count_d     = 4'd0;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // State, shadow and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            count_q       <= 4'd0;
            tmo_q         <= '0;
            a_sh_q        <= 32'd0;
            b_sh_q        <= 32'd0;
            cmd_a_q       <= 32'd0;
            cmd_b_q       <= 32'd0;
            cmd_op_q      <= 4'd0;
            cmd_valid_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_format_q  <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef CALC_FRAME_CHECKSUM_EN
            op_sh_q       <= 8'd0;
            xor_q         <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            tmo_q         <= tmo_d;
            a_sh_q        <= a_sh_d;
            b_sh_q        <= b_sh_d;
            cmd_a_q       <= cmd_a_d;
            cmd_b_q       <= cmd_b_d;
            cmd_op_q      <= cmd_op_d;
            cmd_valid_q   <= cmd_valid_d;
            err_timeout_q <= err_timeout_d;
            err_format_q  <= err_format_d;
            overrun_q     <= overrun_d;
`ifdef CALC_FRAME_CHECKSUM_EN
            op_sh_q       <= op_sh_d;
            xor_q         <= xor_d;
`endif
        end
    end

    assign cmd_a       = cmd_a_q;
    assign cmd_b       = cmd_b_q;
    assign cmd_op      = cmd_op_q;
    assign cmd_valid   = cmd_valid_q;
    assign err_timeout = err_timeout_q;
    assign err_format  = err_format_q;
    assign overrun     = overrun_q;
    assign state       = state_q;

endmodule
